// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the 8-digit hex display scanner.
package disp_pkg;

   localparam int NDIG         = 8;
   localparam int SCAN_DIV_DEF = 100000;
   localparam logic [7:0] AN_OFF = 8'hFF;

   typedef enum logic {
      ST_OFF  = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

endpackage

// File: rtl/disp_if.sv
// Host-side control/data and the digit-drive outputs of the display scanner.
interface disp_if;

   logic        scan_en;
   logic        blank_en;
   logic [31:0] data;
   logic        data_vld;
   logic [7:0]  an;
   logic [3:0]  hex;
   logic        frame_done;

   modport master (
      output scan_en, blank_en, data, data_vld,
      input  an, hex, frame_done
   );

   modport slave (
      input  scan_en, blank_en, data, data_vld,
      output an, hex, frame_done
   );

endinterface

// File: rtl/disp_lz_mask.sv
// Leading-zero visibility: digit i is lit if blanking is off, any nibble at or
// above i is nonzero, or it is digit 0.
module disp_lz_mask
   import disp_pkg::*;
(
   input  logic [31:0] act,
   input  logic        blank_en,
   output logic [7:0]  vis
);

   logic any_nz;

   always_comb begin
      vis    = '0;
      any_nz = 1'b0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         any_nz = any_nz | (|act[4*i +: 4]);
         vis[i] = !blank_en || any_nz || (i == 0);
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed 8-digit hex display scanner with frame-aligned value update.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_OFF  | display dark, prescaler and digit index held
//   ST_SCAN | prescaler running, one digit driven per SCAN_DIV clocks
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = SCAN_DIV_DEF,
   parameter int NDIG     = disp_pkg::NDIG
)(
   input  logic   clk,
   input  logic   rstn,
   disp_if.slave  bus
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = $clog2(NDIG);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [IDX_W-1:0]   idx;
   logic [31:0]        pend, act, load_val;
   logic [7:0]         an_q, an_nxt, vis;
   logic [3:0]         hex_q, hex_nxt;
   logic               fd_q, fd_nxt;
   logic               tick, last_dig, scanning;

   disp_lz_mask u_lz_mask (
      .act      (act),
      .blank_en (bus.blank_en),
      .vis      (vis)
   );

   assign tick     = (cnt == CNT_W'(SCAN_DIV - 1));
   assign last_dig = (idx == IDX_W'(NDIG - 1));
   assign scanning = (state == ST_SCAN) && bus.scan_en;
   // A load coinciding with the reload point bypasses pend straight into act.
   assign load_val = bus.data_vld ? bus.data : pend;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_OFF;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      an_nxt    = AN_OFF;
      hex_nxt   = 4'h0;
      fd_nxt    = 1'b0;
      case (state)
         ST_OFF:  if (bus.scan_en)  state_nxt = ST_SCAN;
         ST_SCAN: if (!bus.scan_en) state_nxt = ST_OFF;
         default: state_nxt = ST_OFF;
      endcase
      if (scanning) begin
         if (vis[idx]) begin
            an_nxt  = AN_OFF & ~(8'(1) << idx);
            hex_nxt = act[{idx, 2'b00} +: 4];
         end
         fd_nxt = tick && last_dig;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt   <= '0;
         idx   <= '0;
         pend  <= '0;
         act   <= '0;
         an_q  <= AN_OFF;
         hex_q <= 4'h0;
         fd_q  <= 1'b0;
      end else begin
         an_q  <= an_nxt;
         hex_q <= hex_nxt;
         fd_q  <= fd_nxt;
         if (bus.data_vld) pend <= bus.data;
         if (state == ST_OFF && bus.scan_en) begin
            act <= load_val;
            cnt <= '0;
            idx <= '0;
         end else if (scanning) begin
            if (tick) begin
               cnt <= '0;
               idx <= idx + 1'b1;
               if (last_dig) act <= load_val;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

   assign bus.an         = an_q;
   assign bus.hex        = hex_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with SCAN_DIV=4 (32-cycle frames).
module tb_disp_scan_ctrl;

   logic clk = 1'b0;
   logic rstn;
   disp_if bus();

   always #5 clk = ~clk;

   disp_scan_ctrl #(.SCAN_DIV(4), .NDIG(8)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [31:0] data;
      logic        blank;
      logic [7:0]  vis;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [7:0] exp_an(input logic [7:0] vis, input int d);
      return vis[d] ? ~(8'h01 << d) : 8'hFF;
   endfunction

   function automatic logic [3:0] exp_hex(input logic [31:0] a, input logic [7:0] vis, input int d);
      return vis[d] ? a[4*d +: 4] : 4'h0;
   endfunction

   task automatic check(input string name, input logic [7:0] ean, input logic [3:0] ehex, input logic efd);
      total++;
      if (bus.an === ean && bus.hex === ehex && bus.frame_done === efd)
         passed++;
      else
         $display("FAIL %s: got an=%h hex=%h fd=%b, expected an=%h hex=%h fd=%b at %0t",
                  name, bus.an, bus.hex, bus.frame_done, ean, ehex, efd, $time);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // k counts edges after SCAN entry; digit (k-1)/4 is on screen, frame ends at k%32==0.
   task automatic run_cycles(input string name, input logic [31:0] a, input logic [7:0] vis,
                             input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         int d;
         step();
         d = ((k - 1) / 4) % 8;
         check(name, exp_an(vis, d), exp_hex(a, vis, d), (k % 32) == 0);
      end
   endtask

   task automatic enter(input logic [31:0] d, input logic vld);
      bus.scan_en  = 1'b1;
      bus.data     = d;
      bus.data_vld = vld;
      step();
      bus.data_vld = 1'b0;
      check("entry_dark", 8'hFF, 4'h0, 1'b0);
   endtask

   task automatic leave();
      bus.scan_en = 1'b0;
      step();
      check("off", 8'hFF, 4'h0, 1'b0);
   endtask

   initial begin
      vecs[0] = '{32'h12345678, 1'b0, 8'hFF};
      vecs[1] = '{32'h000000A0, 1'b1, 8'h03};
      vecs[2] = '{32'h00000000, 1'b1, 8'h01};
      vecs[3] = '{32'h00000000, 1'b0, 8'hFF};
      vecs[4] = '{32'h80000000, 1'b1, 8'hFF};
      vecs[5] = '{32'h00012000, 1'b1, 8'h1F};

      rstn         = 1'b0;
      bus.scan_en  = 1'b0;
      bus.blank_en = 1'b0;
      bus.data     = '0;
      bus.data_vld = 1'b0;
      step();
      step();
      check("reset", 8'hFF, 4'h0, 1'b0);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_no_scan", 8'hFF, 4'h0, 1'b0);
      end

      foreach (vecs[i]) begin
         bus.blank_en = vecs[i].blank;
         enter(vecs[i].data, 1'b1);
         run_cycles($sformatf("vec%0d", i), vecs[i].data, vecs[i].vis, 1, 32);
         leave();
      end

      // Mid-frame load waits for the frame boundary; a load on the idx=7 tick bypasses pend.
      bus.blank_en = 1'b0;
      enter(32'h12345678, 1'b1);
      run_cycles("pre_load", 32'h12345678, 8'hFF, 1, 10);
      bus.data     = 32'hFFFFFFFF;
      bus.data_vld = 1'b1;
      run_cycles("load_edge", 32'h12345678, 8'hFF, 11, 11);
      bus.data_vld = 1'b0;
      run_cycles("old_frame", 32'h12345678, 8'hFF, 12, 32);
      run_cycles("new_frame", 32'hFFFFFFFF, 8'hFF, 33, 63);
      bus.data     = 32'h0000ABCD;
      bus.data_vld = 1'b1;
      run_cycles("tick_load", 32'hFFFFFFFF, 8'hFF, 64, 64);
      bus.data_vld = 1'b0;
      run_cycles("bypass_frame", 32'h0000ABCD, 8'hFF, 65, 96);

      // Drop scan_en mid-digit while idx=3.
      run_cycles("to_idx3", 32'h0000ABCD, 8'hFF, 97, 110);
      bus.scan_en = 1'b0;
      step();
      check("drop_idx3", 8'hFF, 4'h0, 1'b0);
      bus.data     = 32'h00005555;
      bus.data_vld = 1'b1;
      step();
      check("off_load", 8'hFF, 4'h0, 1'b0);
      bus.data_vld = 1'b0;
      step();
      check("off_hold", 8'hFF, 4'h0, 1'b0);
      enter(32'hDEAD0000, 1'b0);
      run_cycles("restart", 32'h00005555, 8'hFF, 1, 8);

      // Asynchronous reset between edges while a digit is lit.
      #2 rstn = 1'b0;
      #1 check("async_rst", 8'hFF, 4'h0, 1'b0);
      @(negedge clk);
      bus.scan_en = 1'b0;
      rstn        = 1'b1;
      step();
      check("post_rst_off", 8'hFF, 4'h0, 1'b0);
      enter(32'hCAFEBABE, 1'b0);
      run_cycles("post_rst_zero", 32'h00000000, 8'hFF, 1, 32);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
